// File: rtl/alu_mc_if.sv
// alu_mc request/result bundle.
// master issues ops and takes results; slave is the ALU.
interface alu_mc_if #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    FS;
  logic [SW-1:0] SH;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [W-1:0]  ext_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  F;
  logic [W-1:0]  F_HI;
  logic          N;
  logic          Z;
  logic          C;
  logic          V;
  logic          D;
  logic          busy;

  modport master (
    output in_valid, FS, SH, A, B, ext_in, out_ready,
    input  in_ready, out_valid, F, F_HI,
    input  N, Z, C, V, D, busy
  );

  modport slave (
    input  in_valid, FS, SH, A, B, ext_in, out_ready,
    output in_ready, out_valid, F, F_HI,
    output N, Z, C, V, D, busy
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU, valid/ready in and out.
// Define ALU_MULDIV_EN for the iterative MUL/DIV datapath.
module alu_mc #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_mc_if.slave io
);
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_SLTU = 4'h3;
  localparam logic [3:0] OP_PASS = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SBB  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_EXT  = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_DIV  = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t       state;
  logic         accept;
  logic         iter_op;
  logic         ld;
  logic [W-1:0] b_op;
  logic         cin;
  logic [W:0]   sum;
  logic [W:0]   shl_w;
  logic [W:0]   shr_w;
  logic [W-1:0] r_f;
  logic         r_c;
  logic         r_v;
  logic [W-1:0] ld_f;
  logic [W-1:0] ld_hi;
  logic         ld_c;
  logic         ld_v;

  assign io.in_ready = rst_n & ((state == IDLE) |
                       ((state == DONE) & io.out_ready));
  assign accept = io.in_valid & io.in_ready;

  // adder operand and carry-in; C=1 means no borrow
  always_comb begin
    b_op = io.B;
    cin  = 1'b0;
    unique case (1'b1)
      io.FS == OP_ADC: cin = io.C;
      io.FS == OP_SUB: begin
        b_op = ~io.B;
        cin  = 1'b1;
      end
      io.FS == OP_SBB: begin
        b_op = ~io.B;
        cin  = io.C;
      end
      default: ;
    endcase
  end

  assign sum   = {1'b0, io.A} + {1'b0, b_op}
               + {{W{1'b0}}, cin};
  assign shl_w = {1'b0, io.A} << io.SH;
  assign shr_w = {io.A, 1'b0} >> io.SH;

  // single-cycle result and carry/overflow
  always_comb begin
    r_f = '0;
    r_c = 1'b0;
    r_v = 1'b0;
    unique case (io.FS)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
        r_f = sum[W-1:0];
        r_c = sum[W];
        r_v = (io.A[W-1] == b_op[W-1]) &
              (sum[W-1] != io.A[W-1]);
      end
      OP_OR:   r_f = io.A | io.B;
      OP_SLTU: r_f = {W{io.A < io.B}};
      OP_PASS: r_f = io.A;
      OP_SHR: begin
        r_f = shr_w[W:1];
        r_c = shr_w[0];
      end
      OP_NOT:  r_f = ~io.A;
      OP_SHL: begin
        r_f = shl_w[W-1:0];
        r_c = shl_w[W];
      end
      OP_XOR:  r_f = io.A ^ io.B;
      OP_EXT:  r_f = io.ext_in;
      OP_AND:  r_f = io.A & io.B;
      OP_MUL, OP_DIV: r_v = 1'b1;
      default: r_v = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [W-1:0]  dv;
  logic          is_div;
  logic [SW-1:0] cnt;
  logic [W-1:0]  c_hi;
  logic [W-1:0]  c_lo;
  logic [W-1:0]  c_dv;
  logic          c_div;
  logic [W:0]    m_sum;
  logic [W:0]    d_sh;
  logic [W:0]    d_df;
  logic          div_ge;
  logic [W-1:0]  hi_n;
  logic [W-1:0]  lo_n;
  logic          last;

  assign iter_op = (io.FS == OP_MUL) |
                   (io.FS == OP_DIV);

  // accept edge runs step 1 straight off the operands
  assign c_hi  = (state == BUSY) ? hi : '0;
  assign c_lo  = (state == BUSY) ? lo : io.A;
  assign c_dv  = (state == BUSY) ? dv : io.B;
  assign c_div = (state == BUSY) ? is_div
                                 : (io.FS == OP_DIV);

  assign m_sum  = {1'b0, c_hi} +
                  (c_lo[0] ? {1'b0, c_dv} : '0);
  assign d_sh   = {c_hi, c_lo[W-1]};
  assign d_df   = d_sh - {1'b0, c_dv};
  assign div_ge = (d_sh >= {1'b0, c_dv});
  assign hi_n   = c_div
    ? (div_ge ? d_df[W-1:0] : d_sh[W-1:0])
    : m_sum[W:1];
  assign lo_n   = c_div
    ? {c_lo[W-2:0], div_ge}
    : {m_sum[0], c_lo[W-1:1]};
  assign last   = (state == BUSY) &
                  (cnt == SW'(W - 1));
`else
  assign iter_op = 1'b0;
  assign io.busy = 1'b0;
`endif

  // choose what lands in the output register
  always_comb begin
    ld    = accept & ~iter_op;
    ld_f  = r_f;
    ld_hi = '0;
    ld_c  = r_c;
    ld_v  = r_v;
`ifdef ALU_MULDIV_EN
    if (last) begin
      ld    = 1'b1;
      ld_f  = lo_n;
      ld_hi = hi_n;
      ld_c  = ~is_div & (hi_n != '0);
      ld_v  = is_div ? (dv == '0)
                     : (hi_n != '0);
    end
`endif
  end

  // FSM, iteration state and the result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      io.out_valid <= 1'b0;
      io.F         <= '0;
      io.F_HI      <= '0;
      io.N         <= 1'b0;
      io.Z         <= 1'b0;
      io.C         <= 1'b0;
      io.V         <= 1'b0;
      io.D         <= 1'b0;
`ifdef ALU_MULDIV_EN
      io.busy      <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      dv           <= '0;
      is_div       <= 1'b0;
      cnt          <= '0;
`endif
    end else begin
      if (ld) begin
        io.F    <= ld_f;
        io.F_HI <= ld_hi;
        io.N    <= ld_f[W-1];
        io.Z    <= (ld_f == '0);
        io.C    <= ld_c;
        io.V    <= ld_v;
        io.D    <= ld_f[W-1] ^ ld_v;
      end
      if (accept) begin
        state        <= iter_op ? BUSY : DONE;
        io.out_valid <= ~iter_op;
`ifdef ALU_MULDIV_EN
        io.busy      <= iter_op;
        hi           <= hi_n;
        lo           <= lo_n;
        dv           <= io.B;
        is_div       <= (io.FS == OP_DIV);
        cnt          <= SW'(1);
`endif
      end else if ((state == DONE) && io.out_ready) begin
        state        <= IDLE;
        io.out_valid <= 1'b0;
      end
`ifdef ALU_MULDIV_EN
      else if (state == BUSY) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          state        <= DONE;
          io.out_valid <= 1'b1;
          io.busy      <= 1'b0;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: vector table, scoreboard and handshake corners.
// Follows ALU_MULDIV_EN the same way as the design.
module tb_alu_mc;
  localparam int W = 8;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] hi;
    logic [4:0] fl;
  } res_t;

  typedef struct {
    logic [3:0] fs;
    logic [2:0] sh;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ext;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb_q[$];
  logic model_c = 1'b0;

  always #5 clk = ~clk;

  alu_mc_if #(.W(W)) io ();

  alu_mc #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  task automatic check(input string name,
                       input logic [31:0] g,
                       input logic [31:0] w);
    n_cmp++;
    if (g !== w) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, g, w);
    end
  endtask

  function automatic res_t got();
    return {io.F, io.F_HI,
            io.N, io.Z, io.C, io.V, io.D};
  endfunction

  function automatic res_t model(
    input logic [3:0] fs, input logic [2:0] sh,
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] ext, input logic cin);
    int s;
    int p;
    int ci;
    logic [7:0] f;
    logic [7:0] hi;
    logic [7:0] t8;
    logic c;
    logic v;
    f = '0;
    hi = '0;
    c = 1'b0;
    v = 1'b0;
    ci = int'(cin);
    case (fs)
      4'h0, 4'h1: begin
        if (fs == 4'h0) ci = 0;
        s = int'(a) + int'(b) + ci;
        p = int'($signed(a)) + int'($signed(b)) + ci;
        f = s[7:0];
        c = s[8];
        v = (p > 127) || (p < -128);
      end
      4'h5, 4'h6: begin
        if (fs == 4'h5) ci = 1;
        s = int'(a) + (255 - int'(b)) + ci;
        p = int'($signed(a)) - int'($signed(b)) - (1 - ci);
        f = s[7:0];
        c = s[8];
        v = (p > 127) || (p < -128);
      end
      4'h2: f = a | b;
      4'h3: f = (a < b) ? 8'hFF : 8'h00;
      4'h4: f = a;
      4'h7: begin
        f = a >> sh;
        t8 = a >> (sh - 3'd1);
        c = (sh != 3'd0) && t8[0];
      end
      4'h8: f = ~a;
      4'h9: begin
        f = a << sh;
        t8 = a << (sh - 3'd1);
        c = (sh != 3'd0) && t8[7];
      end
      4'hA: f = a ^ b;
      4'hB: f = ext;
      4'hC: f = a & b;
`ifdef ALU_MULDIV_EN
      4'hD: begin
        p = int'(a) * int'(b);
        f = p[7:0];
        hi = p[15:8];
        c = (hi != 0);
        v = c;
      end
      4'hE: begin
        if (b == 0) begin
          f = 8'hFF;
          hi = a;
          v = 1'b1;
        end else begin
          f = a / b;
          hi = a % b;
        end
      end
`endif
      default: v = 1'b1;
    endcase
    return {f, hi, f[7], (f == 8'h00), c, v, f[7] ^ v};
  endfunction

  function automatic vec_t mk(
    input logic [3:0] fs, input logic [2:0] sh,
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] ext, input logic [7:0] f,
    input logic [7:0] hi, input logic [4:0] fl);
    vec_t t;
    t.fs = fs;
    t.sh = sh;
    t.a = a;
    t.b = b;
    t.ext = ext;
    t.exp = {f, hi, fl};
    return t;
  endfunction

  // drive one request from posedge+1; push expectation at accept
  task automatic send(
    input logic [3:0] fs, input logic [2:0] sh,
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] ext, output int waits);
    logic acc;
    res_t e;
    acc = 1'b0;
    waits = 0;
    io.in_valid = 1'b1;
    io.FS = fs;
    io.SH = sh;
    io.A = a;
    io.B = b;
    io.ext_in = ext;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = io.in_ready;
      @(posedge clk);
      if (acc) break;
      waits++;
    end
    #1;
    io.in_valid = 1'b0;
    io.A = 8'($urandom);
    io.B = 8'($urandom);
    if (!acc) begin
      check("accept_timeout", 32'(waits), 32'(0));
    end else begin
      e = model(fs, sh, a, b, ext, model_c);
      model_c = e.fl[2];
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (io.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // scoreboard: one pop per output transfer
  always @(negedge clk) begin
    res_t e;
    if (rst_n && io.out_valid && io.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'(sb_q.size()), 32'(1));
      end else begin
        e = sb_q.pop_front();
        check("sb_result", 32'(got()), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int w;
    int lat;
    int exp_lat;
    logic [7:0] ra;
    logic [7:0] rb;

    io.in_valid = 1'b0;
    io.FS = '0;
    io.SH = '0;
    io.A = '0;
    io.B = '0;
    io.ext_in = '0;
    io.out_ready = 1'b0;

    tbl.push_back(mk(4'h0, 0, 8'h7F, 8'h01, 0, 8'h80, 0, 5'b10010));
    tbl.push_back(mk(4'h0, 0, 8'hFF, 8'h01, 0, 8'h00, 0, 5'b01100));
    tbl.push_back(mk(4'h1, 0, 8'h00, 8'h00, 0, 8'h01, 0, 5'b00000));
    tbl.push_back(mk(4'h5, 0, 8'h05, 8'h07, 0, 8'hFE, 0, 5'b10001));
    tbl.push_back(mk(4'h6, 0, 8'h05, 8'h07, 0, 8'hFD, 0, 5'b10001));
    tbl.push_back(mk(4'h2, 0, 8'h0F, 8'h30, 0, 8'h3F, 0, 5'b00000));
    tbl.push_back(mk(4'h3, 0, 8'h03, 8'h04, 0, 8'hFF, 0, 5'b10001));
    tbl.push_back(mk(4'h3, 0, 8'h05, 8'h04, 0, 8'h00, 0, 5'b01000));
    tbl.push_back(mk(4'h4, 0, 8'h5A, 8'hFF, 0, 8'h5A, 0, 5'b00000));
    tbl.push_back(mk(4'h7, 3, 8'h96, 8'h00, 0, 8'h12, 0, 5'b00100));
    tbl.push_back(mk(4'h7, 0, 8'h81, 8'h00, 0, 8'h81, 0, 5'b10001));
    tbl.push_back(mk(4'h8, 0, 8'h0F, 8'h00, 0, 8'hF0, 0, 5'b10001));
    tbl.push_back(mk(4'h9, 3, 8'h96, 8'h00, 0, 8'hB0, 0, 5'b10001));
    tbl.push_back(mk(4'h9, 1, 8'h96, 8'h00, 0, 8'h2C, 0, 5'b00100));
    tbl.push_back(mk(4'hA, 0, 8'hF0, 8'h3C, 0, 8'hCC, 0, 5'b10001));
    tbl.push_back(mk(4'hB, 0, 8'h00, 8'h00, 8'hA5, 8'hA5, 0, 5'b10001));
    tbl.push_back(mk(4'hC, 0, 8'hF0, 8'h3C, 0, 8'h30, 0, 5'b00000));
    tbl.push_back(mk(4'hF, 0, 8'h12, 8'h34, 0, 8'h00, 0, 5'b01011));
    tbl.push_back(mk(4'h0, 0, 8'h80, 8'h80, 0, 8'h00, 0, 5'b01111));
    tbl.push_back(mk(4'h5, 0, 8'h80, 8'h01, 0, 8'h7F, 0, 5'b00111));
`ifdef ALU_MULDIV_EN
    tbl.push_back(mk(4'hD, 0, 8'h12, 8'h34, 0, 8'hA8, 8'h03, 5'b10110));
    tbl.push_back(mk(4'hE, 0, 8'hC8, 8'h07, 0, 8'h1C, 8'h04, 5'b00000));
    tbl.push_back(mk(4'hE, 0, 8'hC8, 8'h00, 0, 8'hFF, 8'hC8, 5'b10010));
    tbl.push_back(mk(4'hD, 0, 8'h0F, 8'h0F, 0, 8'hE1, 8'h00, 5'b10001));
`else
    tbl.push_back(mk(4'hD, 0, 8'h12, 8'h34, 0, 8'h00, 0, 5'b01011));
    tbl.push_back(mk(4'hE, 0, 8'hC8, 8'h07, 0, 8'h00, 0, 5'b01011));
    tbl.push_back(mk(4'hE, 0, 8'hC8, 8'h00, 0, 8'h00, 0, 5'b01011));
`endif

    // reset state
    #12;
    check("reset_state",
          32'({io.out_valid, io.busy, io.in_ready, got()}),
          32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready",
          32'({io.in_ready, io.out_valid, io.busy}),
          32'(3'b100));
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;

    // table vectors with latency
    foreach (tbl[i]) begin
      send(tbl[i].fs, tbl[i].sh, tbl[i].a, tbl[i].b,
           tbl[i].ext, w);
      wait_result(lat);
      check($sformatf("vec%0d_fs%0h", i, tbl[i].fs),
            32'(got()), 32'(tbl[i].exp));
      exp_lat = 1;
`ifdef ALU_MULDIV_EN
      if (tbl[i].fs == 4'hD || tbl[i].fs == 4'hE)
        exp_lat = W;
`endif
      check($sformatf("lat%0d_fs%0h", i, tbl[i].fs),
            32'(lat), 32'(exp_lat));
      @(posedge clk);
      #1;
    end

    // MUL busy window
    send(4'hD, 0, 8'h12, 8'h34, 0, w);
`ifdef ALU_MULDIV_EN
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      check($sformatf("mul_busy_c%0d", i),
            32'({io.busy, io.in_ready, io.out_valid}),
            32'(3'b100));
    end
    @(negedge clk);
    check("mul_done",
          32'({io.busy, io.out_valid, io.F, io.F_HI}),
          32'({2'b01, 8'hA8, 8'h03}));
`else
    @(negedge clk);
    check("mul_reserved",
          32'({io.busy, io.out_valid, io.F, io.F_HI, io.V}),
          32'({2'b01, 8'h00, 8'h00, 1'b1}));
`endif
    @(posedge clk);
    #1;

    // output stall holds result and blocks input
    io.out_ready = 1'b0;
    send(4'h0, 0, 8'h7F, 8'h01, 0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_c%0d", i),
            32'({io.out_valid, io.in_ready, io.F,
                 io.N, io.Z, io.C, io.V, io.D}),
            32'({2'b10, 8'h80, 5'b10010}));
    end
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    send(4'h5, 0, 8'h05, 8'h07, 0, w);
    check("accept_on_release", 32'(w), 32'(0));

    // back-to-back streaming
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send(4'h0, 0, ra, rb, 0, w);
      check($sformatf("stream%0d_wait", i),
            32'(w), 32'(0));
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // reset during MUL
    send(4'hD, 0, 8'h12, 8'h34, 0, w);
    @(posedge clk);
    @(posedge clk);
    #2;
`ifdef ALU_MULDIV_EN
    check("busy_before_reset", 32'(io.busy), 32'(1));
`endif
    rst_n = 1'b0;
    sb_q.delete();
    model_c = 1'b0;
    #1;
    check("reset_mid_op",
          32'({io.out_valid, io.busy, io.in_ready, got()}),
          32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("no_stale_c%0d", i),
            32'({io.in_ready, io.out_valid, io.busy}),
            32'(3'b100));
    end
    @(posedge clk);
    #1;
    send(4'h1, 0, 8'h00, 8'h00, 0, w);
    wait_result(lat);
    check("adc_after_reset", 32'(got()),
          32'({8'h00, 8'h00, 5'b01000}));
    @(posedge clk);
    #1;

    // drain the scoreboard
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check("sb_drain", 32'(sb_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
